// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

    // Unit lifecycle: one boot bubble, normal fetch, terminal halt.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // Every RV32I instruction is one 32-bit word.
    localparam int unsigned INSTR_BYTES = 4;

    // Low PC bits that must be zero for a legal fetch target.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_target_sel.sv
// Next-PC target selection with alignment check (JALR > JAL > branch > +4).
// Latency: purely combinational; this is the single-cycle critical path.
// Backpressure: none; the caller decides whether the target is committed.
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            pc_src,
    input  logic            jump,
    input  logic            jalr,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] seq_target;

    // Candidate targets; all sums wrap modulo 2^XLEN by construction.
    assign jalr_sum   = rs1_data + imm;
    assign rel_target = pc + imm;
    assign seq_target = pc + XLEN'(INSTR_BYTES);

    // Priority mux: JALR clears bit 0 of its sum, JAL and taken branch share pc+imm.
    always_comb begin
        target = seq_target;
        if (jalr) begin
            target = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else if (jump || pc_src) begin
            target = rel_target;
        end
    end

    // A target not on a word boundary cannot be fetched.
    assign misalign = |(target[1:0] & PC_ALIGN_MASK);

endmodule

// File: rtl/pc_update_unit.sv
// Architectural PC register, BOOT/RUN/HALT control, fault capture and retire counter.
// Latency: redirect seen in cycle N appears on pc in cycle N+1; halted/fault registered.
// Backpressure: stall=1 freezes pc, state, counter and fault registers for that cycle.
module pc_update_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            pc_src,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [31:0]     retired
);

    pc_state_t       state_q, state_d;
    logic            boot_armed_q, boot_armed_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     retired_q, retired_d;

    logic [XLEN-1:0] target;
    logic            misalign;

    pc_target_sel #(
        .XLEN(XLEN)
    ) u_target_sel (
        .pc       (pc_q),
        .imm      (imm),
        .rs1_data (rs1_data),
        .pc_src   (pc_src),
        .jump     (jump),
        .jalr     (jalr),
        .target   (target),
        .misalign (misalign)
    );

    // Next-state logic: the first edge after reset release only arms BOOT, so
    // BOOT spans exactly one full cycle; a misaligned target beats halt_req.
    always_comb begin
        state_d      = state_q;
        boot_armed_d = boot_armed_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        retired_d    = retired_q;
        case (state_q)
            BOOT: begin
                if (boot_armed_q) begin
                    state_d = RUN;
                end else begin
                    boot_armed_d = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (misalign) begin
                        state_d    = HALT;
                        fault_d    = 1'b1;
                        fault_pc_d = target;
                    end else begin
                        retired_d = retired_q + 32'd1;
                        if (halt_req) begin
                            state_d = HALT;
                        end else begin
                            pc_d = target;
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC, fault and counter registers; reset restarts the unit at BOOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            boot_armed_q <= 1'b0;
            pc_q         <= RESET_VECTOR;
            fault_q      <= 1'b0;
            fault_pc_q   <= '0;
            retired_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            boot_armed_q <= boot_armed_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
            retired_q    <= retired_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(INSTR_BYTES);
    assign fetch_valid = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign retired     = retired_q;

endmodule
